// File: rtl/apb_master_if.sv
// Signal bundle between the CPU-side request port, the APB master and the APB slave decode.
// The master modport is the requester's view; the slave modport is the mirror for the far side.
interface apb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: one single-beat load/store in flight, SETUP/ACCESS sequencing,
// registered one-cycle response, and a wait-state counter that aborts hung transfers.
module apb_master #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic               resp_timeout_q, resp_timeout_d;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      paddr_q        <= '0;
      pwrite_q       <= 1'b0;
      pwdata_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      paddr_q        <= paddr_d;
      pwrite_q       <= pwrite_d;
      pwdata_q       <= pwdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    paddr_d        = paddr_q;
    pwrite_d       = pwrite_q;
    pwdata_d       = pwdata_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    resp_err_d     = 1'b0;
    resp_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          // Reads leave the previous write data on PWDATA.
          if (bus.req_write) pwdata_d = bus.req_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is tested first so a same-cycle completion beats the timeout.
        if (bus.PREADY) begin
          resp_valid_d = 1'b1;
          resp_err_d   = bus.PSLVERR;
          if (!pwrite_q && !bus.PSLVERR) resp_rdata_d = bus.PRDATA;
          state_d      = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          resp_valid_d   = 1'b1;
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.PSEL         = (state_q != IDLE);
  assign bus.PENABLE      = (state_q == ACCESS);
  assign bus.PADDR        = paddr_q;
  assign bus.PWRITE       = pwrite_q;
  assign bus.PWDATA       = pwdata_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_timeout = resp_timeout_q;

endmodule
